tile_scheduler: RTL and testbench

Top-level sequencer for one matrix-multiply job on the systolic array. It latches the job dimensions and broadcasts `init_cfg` to the loaders. It then walks every weight tile: grant the `kernel_loader` fetch, trigger the weight send, and run all activation (IA) tiles against the resident weights. The next weight fetch is granted while the current tile computes, so loading overlaps compute.

---
 rtl/tile_scheduler.sv | 146 ++++++++++++++
 tb/tb_tile_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tile_scheduler.sv
// Job sequencer for the systolic array: walks weight tiles, overlapping the next
// weight fetch with activation-tile compute on the resident weights.
module tile_scheduler #(
    parameter int SIZE      = 16,
    parameter int REG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [REG_WIDTH-1:0] n,
    input  logic [REG_WIDTH-1:0] m,
    output logic                 init_cfg,
    input  logic                 load_weight_req,
    output logic                 load_weight_granted,
    input  logic                 weight_data_valid,
    output logic                 send_weight_trigger,
    input  logic                 weight_sending_done,
    output logic                 ia_start,
    input  logic                 ia_done,
    input  logic                 err_in,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int CW = REG_WIDTH + 1;
    localparam int LG = $clog2(SIZE);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_WREQ, S_WLOAD, S_WSEND, S_COMP, S_FIN, S_ERR
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   w_tiles_q, w_tiles_d;
    logic [CW-1:0]   ia_tiles_q, ia_tiles_d;
    logic [CW-1:0]   w_idx_q, w_idx_d;
    logic [CW-1:0]   ia_idx_q, ia_idx_d;
    logic            grant_pend_q, grant_pend_d;
    logic            ia_go_q, ia_go_d;

    logic w_last, ia_last, accept, prefetch;

    assign w_last  = (w_idx_q == w_tiles_q - CW'(1));
    assign ia_last = (ia_idx_q == ia_tiles_q - CW'(1));
    assign accept  = start && !err_in && (state_q == S_IDLE || state_q == S_ERR);
    assign busy    = !(state_q == S_IDLE || state_q == S_FIN || state_q == S_ERR);
    assign err     = (state_q == S_ERR);

    always_comb begin
        state_d             = state_q;
        w_tiles_d           = w_tiles_q;
        ia_tiles_d          = ia_tiles_q;
        w_idx_d             = w_idx_q;
        ia_idx_d            = ia_idx_q;
        grant_pend_d        = grant_pend_q;
        ia_go_d             = 1'b0;
        init_cfg            = 1'b0;
        load_weight_granted = 1'b0;
        send_weight_trigger = 1'b0;
        ia_start            = 1'b0;
        done                = 1'b0;
        prefetch            = 1'b0;

        // Counts are widened by one bit so n near 2^REG_WIDTH cannot wrap to zero.
        if (accept) begin
            state_d    = S_CFG;
            w_tiles_d  = ({1'b0, n} + CW'(SIZE - 1)) >> LG;
            ia_tiles_d = ({1'b0, m} + CW'(SIZE - 1)) >> LG;
            w_idx_d    = '0;
        end

        case (state_q)
            S_CFG: begin
                init_cfg = 1'b1;
                state_d  = (w_tiles_q == '0 || ia_tiles_q == '0) ? S_FIN : S_WREQ;
            end
            S_WREQ: if (load_weight_req) begin
                load_weight_granted = 1'b1;
                state_d             = S_WLOAD;
            end
            S_WLOAD: if (weight_data_valid) begin
                send_weight_trigger = 1'b1;
                state_d             = S_WSEND;
            end
            S_WSEND: if (weight_sending_done) begin
                state_d      = S_COMP;
                ia_idx_d     = '0;
                grant_pend_d = 1'b0;
                ia_go_d      = 1'b1;
            end
            S_COMP: begin
                ia_start = ia_go_q;
                prefetch = !w_last && load_weight_req && !grant_pend_q;
                if (prefetch) begin
                    load_weight_granted = 1'b1;
                    grant_pend_d        = 1'b1;
                end
                if (ia_done) begin
                    if (!ia_last) begin
                        ia_idx_d = ia_idx_q + CW'(1);
                        ia_go_d  = 1'b1;
                    end else if (w_last) begin
                        state_d = S_FIN;
                    end else begin
                        w_idx_d = w_idx_q + CW'(1);
                        state_d = (grant_pend_q || prefetch) ? S_WLOAD : S_WREQ;
                    end
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: ;
        endcase

        // Handshakes are withheld on error so the loader never sees a grant that goes nowhere.
        if (err_in && state_q != S_IDLE) begin
            state_d             = S_ERR;
            ia_go_d             = 1'b0;
            load_weight_granted = 1'b0;
            send_weight_trigger = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            w_tiles_q    <= '0;
            ia_tiles_q   <= '0;
            w_idx_q      <= '0;
            ia_idx_q     <= '0;
            grant_pend_q <= 1'b0;
            ia_go_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            w_tiles_q    <= w_tiles_d;
            ia_tiles_q   <= ia_tiles_d;
            w_idx_q      <= w_idx_d;
            ia_idx_q     <= ia_idx_d;
            grant_pend_q <= grant_pend_d;
            ia_go_q      <= ia_go_d;
        end
    end

endmodule

// File: tb/tb_tile_scheduler.sv
// Self-checking bench for tile_scheduler: randomized loader/IA environment with a
// tile-count and event-latency reference model.
module tb_tile_scheduler;

    localparam int SZ = 16;
    localparam int RW = 32;

    logic          clk = 1'b0;
    logic          rst_n, start;
    logic [RW-1:0] n, m;
    logic          init_cfg, load_weight_req, load_weight_granted, weight_data_valid;
    logic          send_weight_trigger, weight_sending_done, ia_start, ia_done;
    logic          err_in, busy, done, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tile_scheduler #(.SIZE(SZ), .REG_WIDTH(RW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n(n), .m(m),
        .init_cfg(init_cfg), .load_weight_req(load_weight_req),
        .load_weight_granted(load_weight_granted), .weight_data_valid(weight_data_valid),
        .send_weight_trigger(send_weight_trigger), .weight_sending_done(weight_sending_done),
        .ia_start(ia_start), .ia_done(ia_done), .err_in(err_in),
        .busy(busy), .done(done), .err(err)
    );

    // Environment state
    int cyc = 0;
    int W, fetched, req_cyc, fetch_rdy_cyc, sdone_cyc, ia_done_cyc, req_lag;
    bit inflight, buf_full, ia_out, spam, err_inj;
    int last_sdone, last_iadone;
    int n_grant, n_trig, n_ia, n_iadone, n_done;
    int init_cyc, done_cyc, first_grant_cyc, grant2_cyc, iadone3_cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic env_reset(input int w);
        W = w; fetched = 0; inflight = 0; buf_full = 0;
        req_cyc = cyc + int'($urandom_range(0, 3));
        fetch_rdy_cyc = -1; sdone_cyc = -1; ia_done_cyc = -1; ia_out = 0;
        last_sdone = -10; last_iadone = -10;
        n_grant = 0; n_trig = 0; n_ia = 0; n_iadone = 0; n_done = 0;
        init_cyc = -1; done_cyc = -1; first_grant_cyc = -1; grant2_cyc = -1; iadone3_cyc = -1;
        spam = 0; err_inj = 0;
    endtask

    // One clock cycle: drive inputs at negedge, sample #1 later, react like the loaders would.
    task automatic step(input bit st);
        @(negedge clk);
        cyc++;
        if (inflight && cyc >= fetch_rdy_cyc) begin
            buf_full = 1; inflight = 0;
        end
        load_weight_req     = (fetched < W) && !inflight && !buf_full && (cyc >= req_cyc);
        weight_data_valid   = buf_full;
        weight_sending_done = (cyc == sdone_cyc);
        ia_done             = (cyc == ia_done_cyc);
        err_in              = err_inj && ia_done && (n_iadone == 0);
        start               = st || (spam && ia_out && !ia_done && ($urandom_range(0, 3) == 0));
        #1;
        if (ia_done) begin
            n_iadone++; last_iadone = cyc; ia_out = 0;
            if (n_iadone == 3) iadone3_cyc = cyc;
        end
        if (weight_sending_done) last_sdone = cyc;
        if (load_weight_granted) begin
            n_grant++;
            if (n_grant == 1) first_grant_cyc = cyc;
            if (n_grant == 2) grant2_cyc = cyc;
            chk("grant_without_req", load_weight_req, 1);
            fetched++; inflight = 1;
            fetch_rdy_cyc = cyc + int'($urandom_range(1, 4));
        end
        if (send_weight_trigger) begin
            n_trig++;
            chk("trigger_without_valid", weight_data_valid, 1);
            buf_full = 0;
            sdone_cyc = cyc + int'($urandom_range(1, 4));
            req_cyc = cyc + int'($urandom_range(0, req_lag));
        end
        if (ia_start) begin
            n_ia++;
            chk("ia_start_overlap", ia_out, 0);
            chk("ia_start_latency", (cyc == last_sdone + 1) || (cyc == last_iadone + 1), 1);
            ia_out = 1;
            ia_done_cyc = cyc + int'($urandom_range(1, 4));
        end
        if (init_cfg) begin
            init_cyc = cyc;
            chk("busy_in_cfg", busy, 1);
            chk("err_in_cfg", err, 0);
        end
        if (done) begin
            n_done++; done_cyc = cyc;
            chk("busy_at_done", busy, 0);
        end
    endtask

    task automatic run_job(input int nn, input int mm, input bit sp);
        int wt, it, t;
        wt = (nn + SZ - 1) / SZ;
        it = (mm + SZ - 1) / SZ;
        env_reset(wt);
        n = RW'(nn); m = RW'(mm);
        step(1);
        t = cyc;
        spam = sp;
        for (int k = 0; k < 3000 && n_done == 0; k++) step(0);
        spam = 0;
        chk("job_done_count", n_done, 1);
        chk("init_cfg_latency", init_cyc, t + 1);
        if (wt * it == 0) chk("zero_done_latency", done_cyc, t + 2);
        else              chk("done_latency", done_cyc, last_iadone + 1);
        chk("grant_count", n_grant, (wt > 0 && it > 0) ? wt : 0);
        chk("trigger_count", n_trig, (wt > 0 && it > 0) ? wt : 0);
        chk("ia_start_count", n_ia, wt * it);
        if (n_grant > 0) chk("first_grant_latency", first_grant_cyc >= t + 2, 1);
        step(0);
        chk("idle_busy", busy, 0);
        chk("idle_err", err, 0);
    endtask

    task automatic async_abort();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_outputs",
            {init_cfg, load_weight_granted, send_weight_trigger, ia_start, busy, done, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 0; n = '0; m = '0;
        load_weight_req = 0; weight_data_valid = 0; weight_sending_done = 0;
        ia_done = 0; err_in = 0; req_lag = 10;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state",
            {init_cfg, load_weight_granted, send_weight_trigger, ia_start, busy, done, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // err_in in IDLE has no effect
        @(negedge clk); err_in = 1;
        @(negedge clk); err_in = 0;
        #1;
        chk("idle_err_in_ignored", {err, busy}, 0);

        // Directed jobs: nominal, partial tiles, zero dimensions
        run_job(32, 48, 0);
        run_job(17, 1, 0);
        run_job(0, 40, 0);
        run_job(40, 0, 0);

        // Prefetch overlap: loader asks again right after each trigger
        req_lag = 0;
        run_job(32, 48, 0);
        chk("prefetch_before_3rd_ia_done", (grant2_cyc > 0) && (grant2_cyc < iadone3_cyc), 1);
        req_lag = 10;

        // Error together with the first ia_done
        env_reset(2);
        n = 32; m = 48; err_inj = 1;
        step(1);
        for (int k = 0; k < 500 && n_iadone == 0; k++) step(0);
        chk("err_first_ia_done_seen", n_iadone, 1);
        err_inj = 0;
        step(0);
        chk("err_set", err, 1);
        chk("err_busy_low", busy, 0);
        chk("err_no_ia_start", ia_start, 0);
        repeat (6) step(0);
        chk("err_no_more_ia_start", n_ia, 1);
        chk("err_sticky", err, 1);
        run_job(32, 48, 0);

        // Asynchronous reset while in WSEND
        env_reset(2);
        n = 32; m = 16;
        step(1);
        for (int k = 0; k < 500 && n_trig == 0; k++) step(0);
        chk("wsend_reached", n_trig, 1);
        @(negedge clk);
        weight_sending_done = 0; ia_done = 0; start = 0;
        #1;
        chk("busy_before_reset", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_job_outputs",
            {init_cfg, load_weight_granted, send_weight_trigger, ia_start, busy, done, err}, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        run_job(32, 48, 0);

        // Tile count must not wrap for n at full scale
        env_reset(1);
        n = '1; m = 16;
        step(1);
        step(0);
        step(0);
        chk("wide_n_not_zero_job", done_cyc, -1);
        chk("wide_n_busy", busy, 1);
        async_abort();

        // Randomized jobs, some with start pulses while busy
        for (int j = 0; j < 12; j++) begin
            req_lag = int'($urandom_range(0, 10));
            run_job(int'($urandom_range(0, 90)), int'($urandom_range(0, 70)),
                    bit'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
